mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion to the team's 4:1 two-bit selector.
- Drives the selector's 2-bit `sel` through a sweep of enabled channels, holding each channel for a programmable dwell time.
- At the end of each dwell it captures the selector's 2-bit output `Y` and publishes one tagged sample per channel, plus an 8-bit snapshot of the whole sweep.
- Used for scanning switch banks or sensor groups through the existing mux.

---
 rtl/mux_scan_sequencer_if.sv | 24 ++
 rtl/mux_scan_sequencer.sv | 83 ++++++++
 tb/tb_mux_scan_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, mux-feedback and sample signals of the scan sequencer
interface mux_scan_sequencer_if #(parameter int DWELL_W = 8);
  logic start;
  logic stop;
  logic cont;
  logic [3:0] chan_en;
  logic [DWELL_W-1:0] dwell;
  logic [1:0] mux_y;
  logic [1:0] sel;
  logic busy;
  logic sample_valid;
  logic [1:0] sample_ch;
  logic [1:0] sample_data;
  logic [7:0] snapshot;
  logic sweep_done;
  modport master (
    output start, stop, cont, chan_en, dwell, mux_y,
    input sel, busy, sample_valid, sample_ch, sample_data, snapshot, sweep_done
  );
  modport slave (
    input start, stop, cont, chan_en, dwell, mux_y,
    output sel, busy, sample_valid, sample_ch, sample_data, snapshot, sweep_done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: sweeps a 4:1 selector over enabled channels and samples its output after each dwell
module mux_scan_sequencer #(parameter int DWELL_W = 8) (
  input logic clk,
  input logic rst_n,
  mux_scan_sequencer_if.slave bus
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state;
  logic [3:0] en_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [1:0] low_in;
  logic [1:0] low_q;
  logic [1:0] next_ch;
  logic has_next;
  // Scan downward so the last hit is the lowest qualifying channel
  always_comb begin
    low_in = 2'd0;
    low_q = 2'd0;
    next_ch = 2'd0;
    has_next = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.chan_en[i]) low_in = 2'(i);
      if (en_q[i]) low_q = 2'(i);
      if (en_q[i] && i > int'(bus.sel)) begin
        next_ch = 2'(i);
        has_next = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      en_q <= 4'd0;
      dwell_q <= '0;
      cnt <= '0;
      bus.sel <= 2'd0;
      bus.busy <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_ch <= 2'd0;
      bus.sample_data <= 2'd0;
      bus.snapshot <= 8'h00;
      bus.sweep_done <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.sweep_done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && !bus.stop && |bus.chan_en) begin
          en_q <= bus.chan_en;
          dwell_q <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          bus.sel <= low_in;
          cnt <= DWELL_W'(1);
          state <= DWELL;
          bus.busy <= 1'b1;
        end
      end else if (bus.stop) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.sel <= 2'd0;
      end else if (cnt < dwell_q) begin
        cnt <= cnt + DWELL_W'(1);
      end else begin
        bus.sample_valid <= 1'b1;
        bus.sample_ch <= bus.sel;
        bus.sample_data <= bus.mux_y;
        bus.snapshot[2*bus.sel +: 2] <= bus.mux_y;
        if (has_next) begin
          bus.sel <= next_ch;
          cnt <= DWELL_W'(1);
        end else begin
          bus.sweep_done <= 1'b1;
          if (bus.cont) begin
            bus.sel <= low_q;
            cnt <= DWELL_W'(1);
          end else begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: table vectors, corner sequences and random sweeps against an event-list model
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ydata = 8'h00;
  logic [7:0] snap_m = 8'h00;
  int checks = 0;
  int errors = 0;
  mux_scan_sequencer_if #(.DWELL_W(8)) bus();
  mux_scan_sequencer #(.DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Behavioural selector: Y = D[sel]
  assign bus.mux_y = ydata[2*bus.sel +: 2];
  typedef struct {
    logic [3:0] en;
    logic [7:0] dw;
    logic [7:0] yd;
    int n;
    int last;
    logic [7:0] snap;
  } vec_t;
  typedef struct {
    int t;
    logic [1:0] ch;
    logic [1:0] d;
  } ev_t;
  vec_t tbl[6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    snap_m = 8'h00;
  endtask
  // Expected events: k-th enabled channel sampled k*D cycles after the start edge
  task automatic run_sweep(input logic [3:0] en, input logic [7:0] dw, input logic [7:0] yd,
                           input bit scramble, output int n, output int last,
                           output int dones, output int done_at, output int busy_cnt);
    ev_t q[$];
    ev_t e;
    int d;
    int k;
    bit ended;
    d = (dw == 0) ? 1 : int'(dw);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        k++;
        e.t = k * d;
        e.ch = 2'(i);
        e.d = yd[2*i +: 2];
        q.push_back(e);
      end
    end
    n = 0; last = 0; dones = 0; done_at = 0; ended = 0;
    ydata = yd;
    bus.chan_en = en;
    bus.dwell = dw;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int t = 1; t <= 400; t++) begin
      if (scramble) begin
        bus.chan_en = 4'($urandom);
        bus.dwell = 8'($urandom);
        bus.start = 1'($urandom);
      end
      tick();
      if (bus.sample_valid) begin
        n++;
        last = t;
        if (q.size() == 0) check("extra_sample", 1, 0);
        else begin
          e = q.pop_front();
          check("sample_time", t, e.t);
          check("sample_ch", bus.sample_ch, e.ch);
          check("sample_data", bus.sample_data, e.d);
          snap_m[2*e.ch +: 2] = e.d;
          check("done_on_last", bus.sweep_done, q.size() == 0);
        end
      end else if (bus.sweep_done) check("done_without_sample", 1, 0);
      if (bus.sweep_done) begin
        dones++;
        done_at = t;
      end
      if (!bus.busy) begin
        ended = 1;
        break;
      end
      busy_cnt++;
    end
    bus.start = 1'b0;
    check("sweep_timeout", ended, 1);
    check("missing_samples", q.size(), 0);
    check("snapshot_model", bus.snapshot, snap_m);
  endtask
  initial begin
    int n, last, dones, done_at, busy_cnt, cnt_s, cnt_d, last_s;
    bit bad;
    tbl[0] = '{4'b1111, 8'd2, 8'b00_11_10_01, 4, 8, 8'h39};
    tbl[1] = '{4'b1010, 8'd0, 8'b10_01_11_01, 2, 2, 8'h8C};
    tbl[2] = '{4'b0100, 8'd5, 8'b00_10_00_00, 1, 5, 8'h20};
    tbl[3] = '{4'b1001, 8'd3, 8'b11_00_00_10, 2, 6, 8'hC2};
    tbl[4] = '{4'b0110, 8'd1, 8'b01_11_10_00, 2, 2, 8'h38};
    tbl[5] = '{4'b1000, 8'd255, 8'b01_00_00_00, 1, 255, 8'h40};
    bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
    bus.chan_en = 4'd0; bus.dwell = 8'd0;
    repeat (2) tick();
    check("rst_sel", bus.sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_snapshot", bus.snapshot, 0);
    check("rst_done", bus.sweep_done, 0);
    check("rst_ch_data", {bus.sample_ch, bus.sample_data}, 0);
    rst_n = 1'b1;
    foreach (tbl[v]) begin
      do_reset();
      run_sweep(tbl[v].en, tbl[v].dw, tbl[v].yd, 0, n, last, dones, done_at, busy_cnt);
      check("tbl_samples", n, tbl[v].n);
      check("tbl_last", last, tbl[v].last);
      check("tbl_dones", dones, 1);
      check("tbl_done_at", done_at, tbl[v].last);
      check("tbl_busy_cycles", busy_cnt, tbl[v].last);
      check("tbl_snapshot", bus.snapshot, tbl[v].snap);
    end
    // Asynchronous reset in the middle of a sweep
    do_reset();
    ydata = 8'h39; bus.chan_en = 4'b1111; bus.dwell = 8'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("pre_rst_snapshot", bus.snapshot, 8'h09);
    check("pre_rst_sel", bus.sel, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", bus.sel, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_snapshot", bus.snapshot, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.sample_valid || bus.busy) bad = 1;
    end
    check("post_rst_quiet", bad, 0);
    // Continuous mode with mid-run dwell change, then cont dropped
    ydata = 8'h02; bus.chan_en = 4'b0001; bus.dwell = 8'd3; bus.cont = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt_s = 0; cnt_d = 0; last_s = 0; bad = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 4) bus.dwell = 8'd1;
      if (t == 10) bus.cont = 1'b0;
      if (bus.sample_valid) begin
        cnt_s++;
        last_s = t;
        if (t % 3 != 0 || bus.sample_ch != 2'd0 || bus.sample_data != 2'b10 || !bus.sweep_done) bad = 1;
      end
      if (bus.sweep_done) cnt_d++;
    end
    check("cont_samples", cnt_s, 4);
    check("cont_dones", cnt_d, 4);
    check("cont_last", last_s, 12);
    check("cont_pattern", bad, 0);
    check("cont_idle", bus.busy, 0);
    // Abort during second channel's dwell
    do_reset();
    ydata = 8'h39; bus.chan_en = 4'b1111; bus.dwell = 8'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("abort_pre_sel", bus.sel, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_sel", bus.sel, 0);
    check("abort_no_sample", bus.sample_valid, 0);
    check("abort_no_done", bus.sweep_done, 0);
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.sample_valid || bus.busy || bus.sweep_done) bad = 1;
    end
    check("abort_quiet", bad, 0);
    check("abort_snapshot", bus.snapshot, 8'h01);
    // Start collisions in IDLE
    bus.start = 1'b1; bus.stop = 1'b1; bus.chan_en = 4'b1111;
    tick();
    check("start_stop_idle", bus.busy, 0);
    bus.stop = 1'b0; bus.chan_en = 4'b0000;
    tick();
    check("start_no_chan", bus.busy, 0);
    bus.start = 1'b0;
    // Random sweeps with inputs scrambled while busy
    do_reset();
    for (int r = 0; r < 40; r++) begin
      run_sweep(4'($urandom_range(1, 15)), 8'($urandom_range(0, 6)), 8'($urandom),
                1, n, last, dones, done_at, busy_cnt);
      check("rand_dones", dones, 1);
      check("rand_busy_cycles", busy_cnt, last);
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
